// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - shared widths, opcode enumeration and instruction layout for the decoder and ALU
package id_pkg;

  localparam int INSTR_W = 6;
  localparam int OP_W    = 3;
  localparam int ADDR_W  = 2;
  localparam int NREG    = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_LD  = 3'b010,
    OP_ST  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_AND = 3'b110,
    OP_OR  = 3'b111
  } op_e;

  // Field order matches the bit layout of the instruction word, MSB first.
  typedef struct packed {
    logic              acc_en;
    op_e               op;
    logic [ADDR_W-1:0] addr;
  } instr_t;

  function automatic instr_t unpack_instr(input logic [INSTR_W-1:0] word);
    return instr_t'(word);
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// rtl/onehot_dec.sv - combinational 2-to-4 one-hot decoder
module onehot_dec
  import id_pkg::*;
(
  input  logic [ADDR_W-1:0] in_addr,
  output logic [NREG-1:0]   onehot
);

  always_comb begin
    onehot          = '0;
    onehot[in_addr] = 1'b1;
  end

endmodule

// File: rtl/id_unit.sv
// rtl/id_unit.sv - instruction decode stage: registers opcode/address and
// issues single-cycle register-file and accumulator enables
module id_unit
  import id_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               ID_CE,
  input  logic [INSTR_W-1:0] INSTR,
  output logic [OP_W-1:0]    OP_CODE,
  output logic [ADDR_W-1:0]  ADDR,
  output logic [NREG-1:0]    CE,
  output logic               ACC_CE
);

  instr_t            instr;
  logic [NREG-1:0]   addr_onehot;

  logic [OP_W-1:0]   op_code_q, op_code_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [NREG-1:0]   ce_q,      ce_d;
  logic              acc_ce_q,  acc_ce_d;

  assign instr = unpack_instr(INSTR);

  onehot_dec u_onehot_dec (
    .in_addr (instr.addr),
    .onehot  (addr_onehot)
  );

  // Opcode and address hold between accepts; enables pulse for one cycle only.
  always_comb begin
    op_code_d = op_code_q;
    addr_d    = addr_q;
    ce_d      = '0;
    acc_ce_d  = 1'b0;
    if (ID_CE) begin
      op_code_d = instr.op;
      addr_d    = instr.addr;
      acc_ce_d  = instr.acc_en;
      if (instr.op == OP_ST) begin
        ce_d = addr_onehot;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_code_q <= '0;
      addr_q    <= '0;
      ce_q      <= '0;
      acc_ce_q  <= 1'b0;
    end else begin
      op_code_q <= op_code_d;
      addr_q    <= addr_d;
      ce_q      <= ce_d;
      acc_ce_q  <= acc_ce_d;
    end
  end

  assign OP_CODE = op_code_q;
  assign ADDR    = addr_q;
  assign CE      = ce_q;
  assign ACC_CE  = acc_ce_q;

endmodule

// File: tb/tb_id_unit.sv
// tb/tb_id_unit.sv - scoreboard bench for id_unit with directed and random stimulus
module tb_id_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       ID_CE;
  logic [5:0] INSTR;
  logic [2:0] OP_CODE;
  logic [1:0] ADDR;
  logic [3:0] CE;
  logic       ACC_CE;

  id_unit dut (
    .clk     (clk),
    .rst     (rst),
    .ID_CE   (ID_CE),
    .INSTR   (INSTR),
    .OP_CODE (OP_CODE),
    .ADDR    (ADDR),
    .CE      (CE),
    .ACC_CE  (ACC_CE)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    op;
    int    addr;
    int    ce;
    int    acc;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state: last accepted opcode/address.
  int m_op   = 0;
  int m_addr = 0;

  function automatic exp_t model_step(input bit r, input bit ce, input int ins, input string tag);
    exp_t e;
    e.tag = tag;
    if (r) begin
      m_op = 0;
      m_addr = 0;
      e.ce = 0;
      e.acc = 0;
    end else if (ce) begin
      m_op   = (ins / 4) % 8;
      m_addr = ins % 4;
      e.acc  = ins / 32;
      e.ce   = (m_op == 3) ? (1 << m_addr) : 0;
    end else begin
      e.ce  = 0;
      e.acc = 0;
    end
    e.op   = m_op;
    e.addr = m_addr;
    return e;
  endfunction

  task automatic drive(input bit r, input bit ce, input int ins, input string tag);
    @(posedge clk);
    #1;
    rst   = r;
    ID_CE = ce;
    INSTR = ins[5:0];
    exp_q.push_back(model_step(r, ce, ins, tag));
  endtask

  // Monitor: every falling edge checks the values registered at the preceding rising edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if (int'(OP_CODE) != e.op || int'(ADDR) != e.addr || int'(CE) != e.ce || int'(ACC_CE) != e.acc) begin
        miscompares++;
        $display("FAIL %s: got op=%0d addr=%0d ce=%b acc=%0d, want op=%0d addr=%0d ce=%b acc=%0d",
                 e.tag, OP_CODE, ADDR, CE, ACC_CE, e.op, e.addr, e.ce[3:0], e.acc);
      end
      vectors++;
      if ($countones(CE) > 1) begin
        miscompares++;
        $display("FAIL onehot_%s: got ce=%b, want at most one bit set", e.tag, CE);
      end
    end
  end

  initial begin
    rst   = 1'b1;
    ID_CE = 1'b1;
    INSTR = 6'b111111;
    exp_q.push_back(model_step(1'b1, 1'b1, 63, "reset_0"));
    drive(1'b1, 1'b1, 63, "reset_1");
    drive(1'b0, 1'b0, 63, "post_reset");
    drive(1'b0, 1'b0, 0,  "post_reset_idle");

    drive(1'b0, 1'b1, 6'b000010, "add");
    drive(1'b0, 1'b1, 6'b101111, "st_acc");
    drive(1'b0, 1'b1, 6'b010001, "xor_accept");
    drive(1'b0, 1'b0, 6'b000000, "xor_hold");
    drive(1'b0, 1'b0, 6'b111111, "xor_hold2");

    for (int i = 0; i < 64; i++) begin
      drive(1'b0, 1'b1, i, $sformatf("sweep_%0d", i));
    end

    drive(1'b0, 1'b1, 6'b001100, "st_r0");
    drive(1'b1, 1'b1, 6'b101111, "mid_reset");
    drive(1'b0, 1'b0, 6'b101111, "after_mid_reset");

    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 63)), $sformatf("rand_%0d", i));
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
